spi_stream_master: RTL and testbench

- Parametrised successor to the fixed 8-bit serial-clock/shift-register/program-counter display path.
- On start, streams a sequence of command/data words from an external synchronous memory over a 4-wire SPI link (sclk, mosi, cs_n, dc).
- Runtime-selectable SPI mode, configurable word width and clock divider, end-of-stream marker, and abort.
- Sits between the instruction memory and the display GPIO pins.

---
 rtl/spi_stream_master.sv | 208 ++++++++++++++++++++
 tb/tb_spi_stream_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_stream_master.sv
// Streams {last, dc, payload} words from a synchronous memory over a 4-wire SPI link.
// Define SPI_STREAM_MISO_EN to add the miso receive path (miso, rx_data, rx_valid).
module spi_stream_master #(
    parameter int DATA_BITS  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MEM_BITS   = DATA_BITS + 2,
    parameter int DIV_HALF   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  cpol,
    input  logic                  cpha,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_BITS-1:0]   mem_data,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  dc,
    output logic                  busy,
    output logic                  done,
`ifdef SPI_STREAM_MISO_EN
    input  logic                  miso,
    output logic [DATA_BITS-1:0]  rx_data,
    output logic                  rx_valid,
`endif
    output logic [ADDR_WIDTH-1:0] word_count
);

    localparam int DIV_W  = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_BITS + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(DIV_HALF - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_BITS);
    localparam logic [EDGE_W-1:0] EDGE_THREE = EDGE_W'(3);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StSetup,
        StShift,
        StHold
    } stateT;

    stateT                  state;
    logic                   cpolQ;
    logic                   cphaQ;
    logic                   lastQ;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [DATA_BITS-2:0]   shiftReg;
    logic [DIV_W-1:0]       divCnt;
    logic [EDGE_W-1:0]      edgeCnt;

    logic [EDGE_W-1:0]      edgeNext;
    logic                   edgeFire;
    logic                   wordEnd;
    logic                   doShift;
    logic                   doSample;
    logic                   abortHit;

    // Edges are numbered 1..2*DATA_BITS; odd numbers are leading edges.
    always_comb begin
        edgeNext = edgeCnt + 1'b1;
        edgeFire = ((state == StSetup) || (state == StShift)) && (divCnt == DIV_LAST);
        wordEnd  = edgeFire && (edgeNext == EDGE_LAST);
        if (cphaQ) begin
            doShift = edgeFire && edgeNext[0] && (edgeNext >= EDGE_THREE);
        end else begin
            doShift = edgeFire && !edgeNext[0] && (edgeNext != EDGE_LAST);
        end
        doSample = edgeFire && (edgeNext[0] ^ cphaQ);
        abortHit = abort && (state != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            cpolQ      <= 1'b0;
            cphaQ      <= 1'b0;
            lastQ      <= 1'b0;
            addr       <= '0;
            shiftReg   <= '0;
            divCnt     <= '0;
            edgeCnt    <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            dc         <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            done <= 1'b0;
            if (abortHit) begin
                // mosi, dc and word_count deliberately keep their values
                state  <= StIdle;
                cs_n   <= 1'b1;
                sclk   <= cpolQ;
                mem_rd <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        sclk <= cpolQ;
                        if (start && !abort) begin
                            cpolQ      <= cpol;
                            cphaQ      <= cpha;
                            addr       <= base_addr;
                            sclk       <= cpol;
                            cs_n       <= 1'b0;
                            busy       <= 1'b1;
                            word_count <= '0;
                            mem_rd     <= 1'b1;
                            mem_addr   <= base_addr;
                            state      <= StFetch;
                        end
                    end
                    StFetch: begin
                        mem_rd <= 1'b0;
                        state  <= StLoad;
                    end
                    StLoad: begin
                        shiftReg <= mem_data[DATA_BITS-2:0];
                        mosi     <= mem_data[DATA_BITS-1];
                        dc       <= mem_data[DATA_BITS];
                        lastQ    <= mem_data[DATA_BITS+1];
                        divCnt   <= '0;
                        edgeCnt  <= '0;
                        state    <= StSetup;
                    end
                    StSetup, StShift: begin
                        if (edgeFire) begin
                            divCnt  <= '0;
                            sclk    <= ~sclk;
                            edgeCnt <= edgeNext;
                            state   <= StShift;
                            if (doShift) begin
                                mosi     <= shiftReg[DATA_BITS-2];
                                shiftReg <= shiftReg << 1;
                            end
                            if (wordEnd) begin
                                word_count <= word_count + 1'b1;
                                addr       <= addr + 1'b1;
                                if (lastQ) begin
                                    state <= StHold;
                                end else begin
                                    mem_rd   <= 1'b1;
                                    mem_addr <= addr + 1'b1;
                                    state    <= StFetch;
                                end
                            end
                        end else begin
                            divCnt <= divCnt + 1'b1;
                        end
                    end
                    StHold: begin
                        if (divCnt == DIV_LAST) begin
                            cs_n  <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= StIdle;
                        end else begin
                            divCnt <= divCnt + 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

`ifdef SPI_STREAM_MISO_EN
    logic [DATA_BITS-1:0] rxShift;
    logic                 rxPend;

    // A completed word is published one cycle after its final sclk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxShift  <= '0;
            rxPend   <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rxPend) begin
                rx_data  <= rxShift;
                rx_valid <= 1'b1;
            end
            if (abortHit) begin
                rxShift <= '0;
                rxPend  <= 1'b0;
            end else begin
                rxPend <= wordEnd;
                if (doSample) begin
                    rxShift <= {rxShift[DATA_BITS-2:0], miso};
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_spi_stream_master.sv
// Self-checking bench for spi_stream_master: table vectors, random transactions against a
// bus-level reference model, and directed abort / start-collision / optional miso sequences.
module tb_spi_stream_master;

    localparam int DB = 8;
    localparam int AW = 16;
    localparam int MB = DB + 2;
    localparam int DH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [MB-1:0] mem_data = '0;
    logic          sclk, mosi, cs_n, dc, busy, done;
    logic [AW-1:0] word_count;
`ifdef SPI_STREAM_MISO_EN
    logic          miso;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
`endif

    logic [MB-1:0] mem [0:(1<<AW)-1];
    int vecCnt = 0;
    int errCnt = 0;

    always #5 clk = ~clk;

    spi_stream_master #(
        .DATA_BITS(DB), .ADDR_WIDTH(AW), .MEM_BITS(MB), .DIV_HALF(DH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .base_addr(base_addr),
        .cpol(cpol), .cpha(cpha), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .dc(dc), .busy(busy), .done(done),
`ifdef SPI_STREAM_MISO_EN
        .miso(miso), .rx_data(rx_data), .rx_valid(rx_valid),
`endif
        .word_count(word_count)
    );

    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    // Bus monitor: decodes SPI frames from the pins using the transaction's mode.
    int            cyc = 0;
    bit            monCpol, monCpha;
    logic          prevSclk = 1'b0, prevCs = 1'b1;
    int            edgeInWord, bitCnt, wordsEnded, lastEndCyc, doneCnt, doneCyc, dcErr;
    logic [DB-1:0] bits;
    logic          curDc;
    logic [DB:0]   capWords [$];
    int            gaps [$];
`ifdef SPI_STREAM_MISO_EN
    int            rxValidCnt, rxValidCyc;
    logic [DB-1:0] slvPat = '0;
    int            slvIdx = 0;
    always @(negedge cs_n) slvIdx = 0;
    always @(posedge sclk) if (cs_n == 1'b0) slvIdx++;
    assign miso = (slvIdx < DB) ? slvPat[DB-1-slvIdx] : 1'b0;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && prevCs == 1'b0 && cs_n == 1'b0 && sclk != prevSclk) begin
            if (edgeInWord == 0 && wordsEnded > 0) gaps.push_back(cyc - lastEndCyc);
            edgeInWord++;
            // leading edge leaves the idle level; CPHA=0 samples leading, CPHA=1 trailing
            if ((prevSclk == monCpol) != monCpha) begin
                if (bitCnt == 0) curDc = dc;
                else if (dc !== curDc) dcErr++;
                bits = {bits[DB-2:0], mosi};
                bitCnt++;
                if (bitCnt == DB) begin
                    capWords.push_back({curDc, bits});
                    bitCnt = 0;
                end
            end
            if (edgeInWord == 2 * DB) begin
                edgeInWord = 0;
                wordsEnded++;
                lastEndCyc = cyc;
            end
        end
        if (done === 1'b1) begin
            doneCnt++;
            doneCyc = cyc;
        end
`ifdef SPI_STREAM_MISO_EN
        if (rx_valid === 1'b1) begin
            rxValidCnt++;
            rxValidCyc = cyc;
        end
`endif
        prevSclk = sclk;
        prevCs   = cs_n;
    end

    task automatic monReset(input bit pol, input bit pha);
        monCpol = pol; monCpha = pha;
        edgeInWord = 0; bitCnt = 0; wordsEnded = 0; lastEndCyc = 0;
        doneCnt = 0; doneCyc = 0; dcErr = 0;
        capWords.delete();
        gaps.delete();
`ifdef SPI_STREAM_MISO_EN
        rxValidCnt = 0; rxValidCyc = 0;
`endif
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Full transaction against the reference model: walk memory from base until a last flag.
    task automatic runTxn(input logic [AW-1:0] base, input bit pol, input bit pha, input bit poke);
        logic [MB-1:0] expQ [$];
        logic [AW-1:0] a;
        int            guard;
        a = base;
        for (int i = 0; i < 16; i++) begin
            expQ.push_back(mem[a]);
            if (mem[a][DB+1]) break;
            a = a + 1'b1;
        end
        monReset(pol, pha);
        @(negedge clk);
        start = 1'b1; base_addr = base; cpol = pol; cpha = pha;
        @(negedge clk);
        start = 1'b0; cpol = 1'($urandom); cpha = 1'($urandom); base_addr = AW'($urandom);
        check("busy after start", busy, 1);
        check("cs_n after start", cs_n, 0);
        check("word_count cleared", word_count, 0);
        guard = 0;
        while (done !== 1'b1 && guard < 3000) begin
            start = (poke && guard == 50) ? 1'b1 : 1'b0;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check("done seen", done, 1);
        check("cs_n at done", cs_n, 1);
        check("busy at done", busy, 0);
        check("word_count", word_count, expQ.size());
        check("sclk idle at done", sclk, pol);
        check("mem_addr last fetch", mem_addr, a);
        repeat (3) @(negedge clk);
        check("busy stays idle", busy, 0);
        check("done pulse width", doneCnt, 1);
        check("done delay after last edge", doneCyc - lastEndCyc, DH);
        check("dc stable per word", dcErr, 0);
        check("words captured", capWords.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < capWords.size(); i++)
            check("word dc+payload", capWords[i], expQ[i][DB:0]);
        for (int i = 0; i < gaps.size(); i++)
            check("inter-word gap", gaps[i], 2 + DH);
    endtask

    typedef struct packed {
        logic [AW-1:0]      base;
        bit                 pol;
        bit                 pha;
        int                 n;
        logic [3:0][MB-1:0] w;
    } vecT;

    vecT vecs [5];

    initial begin
        int            guard;
        int            n;
        logic [AW-1:0] b;
        bit            pol, pha;

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        vecs[0] = '{base: 16'h0000, pol: 1'b0, pha: 1'b0, n: 1,
                    w: {10'h000, 10'h000, 10'h000, 10'h3A5}};
        vecs[1] = '{base: 16'h0010, pol: 1'b0, pha: 1'b0, n: 3,
                    w: {10'h000, 10'h3FF, 10'h181, 10'h03C}};
        vecs[2] = '{base: 16'h0020, pol: 1'b1, pha: 1'b1, n: 1,
                    w: {10'h000, 10'h000, 10'h000, 10'h25A}};
        vecs[3] = '{base: 16'hFFFF, pol: 1'b0, pha: 1'b1, n: 2,
                    w: {10'h000, 10'h000, 10'h234, 10'h112}};
        vecs[4] = '{base: 16'h1234, pol: 1'b1, pha: 1'b0, n: 4,
                    w: {10'h3FF, 10'h000, 10'h155, 10'h0AA}};

        repeat (3) @(negedge clk);
        check("reset sclk", sclk, 0);
        check("reset cs_n", cs_n, 1);
        check("reset mosi", mosi, 0);
        check("reset dc", dc, 0);
        check("reset mem_rd", mem_rd, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset word_count", word_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < vecs[i].n; j++) mem[vecs[i].base + AW'(j)] = vecs[i].w[j];
            runTxn(vecs[i].base, vecs[i].pol, vecs[i].pha, 1'b0);
            check("table word_count", word_count, vecs[i].n);
        end

        // start and abort together in IDLE: abort wins
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("start+abort busy", busy, 0);
        check("start+abort cs_n", cs_n, 1);
        check("start+abort mem_rd", mem_rd, 0);

        // abort in the middle of the second word
        mem[16'h0040] = 10'h011; mem[16'h0041] = 10'h122; mem[16'h0042] = 10'h3C3;
        monReset(1'b0, 1'b0);
        @(negedge clk); start = 1'b1; base_addr = 16'h0040; cpol = 1'b0; cpha = 1'b0;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (!(wordsEnded >= 1 && edgeInWord >= 5) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("abort point reached", wordsEnded, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort cs_n", cs_n, 1);
        check("abort busy", busy, 0);
        check("abort sclk", sclk, 0);
        check("abort mem_rd", mem_rd, 0);
        repeat (20) @(negedge clk);
        check("abort no done", doneCnt, 0);
        check("abort word_count", word_count, 1);
        check("abort words captured", capWords.size(), 1);
        runTxn(16'h0040, 1'b0, 1'b0, 1'b0);

        // randomized transactions, with stray starts poked in while busy
        for (int t = 0; t < 24; t++) begin
            n   = $urandom_range(1, 4);
            b   = AW'($urandom);
            pol = 1'($urandom);
            pha = 1'($urandom);
            for (int j = 0; j < n; j++)
                mem[b + AW'(j)] = {(j == n - 1) ? 1'b1 : 1'b0, 1'($urandom), DB'($urandom)};
            runTxn(b, pol, pha, 1'($urandom));
        end

`ifdef SPI_STREAM_MISO_EN
        slvPat = 8'hC3;
        mem[16'h0050] = 10'h3A5;
        runTxn(16'h0050, 1'b0, 1'b0, 1'b0);
        check("rx_data", rx_data, 8'hC3);
        check("rx_valid pulses", rxValidCnt, 1);
        check("rx_valid delay", rxValidCyc - lastEndCyc, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule
